// File: rtl/chunked_add_sequencer.sv
// chunked_add_sequencer: W = 3*N_CHUNKS bit adder, one 3-bit chunk per clock.
// Ports: clk, rst_n, start/a/b/cin in; busy, done, sum, cout out.

// three_bit_adder: 3-bit ripple slice.
// Ports: x, y, cin in; s, cout out.
module three_bit_adder (
    input  logic [2:0] x,
    input  logic [2:0] y,
    input  logic       cin,
    output logic [2:0] s,
    output logic       cout
);
    logic [3:0] c;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < 3; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        cout = c[3];
    end
endmodule

module chunked_add_sequencer #(
    parameter int N_CHUNKS = 4,
    parameter int W        = 3 * N_CHUNKS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int IW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          carry_r;
    logic [IW-1:0] idx;
    logic [2:0]    x_chunk;
    logic [2:0]    y_chunk;
    logic [2:0]    s3;
    logic          c3;

    assign x_chunk = a_r[3*idx +: 3];
    assign y_chunk = b_r[3*idx +: 3];

    three_bit_adder u_add (
        .x    (x_chunk),
        .y    (y_chunk),
        .cin  (carry_r),
        .s    (s3),
        .cout (c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (idx == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode the state flop only; start never reaches them directly.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        idx     <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                    end
                end
                RUN: begin
                    sum[3*idx +: 3] <= s3;
                    carry_r         <= c3;
                    if (idx == LAST) begin
                        cout <= c3;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_chunked_add_sequencer.sv
// tb_chunked_add_sequencer: scoreboard bench for chunked_add_sequencer.
// Expected {cout,sum} pushed on drive, popped on done.
module tb_chunked_add_sequencer;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] a;
    logic [11:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [11:0] sum;
    logic        cout;

    int n_checks;
    int n_errors;
    int n_done;
    logic [12:0] sb[$];

    chunked_add_sequencer #(.N_CHUNKS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                chk("result", {19'd0, cout, sum}, {19'd0, sb.pop_front()});
            end
        end
    end

    function automatic logic [12:0] model(input logic [11:0] x,
                                          input logic [11:0] y,
                                          input logic c);
        return {1'b0, x} + {1'b0, y} + {12'd0, c};
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge, idle.
    task automatic do_op(input logic [11:0] a_v, input logic [11:0] b_v,
                         input logic c_v, input bit keep);
        int lat;
        int nb;
        logic [12:0] e;
        lat = 0;
        nb = 0;
        e = model(a_v, b_v, c_v);
        a = a_v;
        b = b_v;
        cin = c_v;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (!keep) start = 1'b0;
            if (busy) nb++;
            if (done) lat = k;
        end
        chk("latency", lat, 5);
        chk("busy_cycles", nb, 5);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("sum_hold", {19'd0, cout, sum}, {19'd0, e});
    endtask

    initial begin
        int d0;
        int lat;
        n_checks = 0;
        n_errors = 0;
        n_done = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {20'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(12'h123, 12'h456, 1'b1, 1'b0);
        do_op(12'hFFF, 12'h001, 1'b0, 1'b0);
        do_op(12'hFFF, 12'hFFF, 1'b1, 1'b0);

        // start and operand changes during RUN are ignored
        d0 = n_done;
        a = 12'h111;
        b = 12'h222;
        cin = 1'b0;
        start = 1'b1;
        sb.push_back(model(12'h111, 12'h222, 1'b0));
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        a = 12'hAAA;
        b = 12'h555;
        cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int k = 0; k < 20 && lat == 0; k++) begin
            @(negedge clk);
            if (done) lat = 1;
        end
        chk("run_ignore_done", lat, 1);
        repeat (10) @(negedge clk);
        chk("run_ignore_count", n_done - d0, 1);
        chk("run_ignore_busy", {31'd0, busy}, 32'd0);

        // reset during the second RUN cycle
        a = 12'h123;
        b = 12'h456;
        cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        d0 = n_done;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_sum", {19'd0, cout, sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_no_done", n_done - d0, 0);
        do_op(12'h00F, 12'h001, 1'b0, 1'b0);

        // start held high, back-to-back random ops
        for (int i = 0; i < 1000; i++) begin
            do_op(12'($urandom), 12'($urandom), 1'($urandom), 1'b1);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
